// File: rtl/rand_shuffle_sched.sv
// Fisher-Yates permutation generator: fills a local index table, then draws
// swap partners from the LFSR word by rejection sampling and streams indices out.
module rand_shuffle_sched #(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned RND_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W:0]   count,
   input  logic [RND_W-1:0] rnd_in,
   output logic             rnd_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int unsigned DEPTH = 2 ** IDX_W;
   localparam int unsigned CNT_W = IDX_W + 1;

   typedef enum logic [2:0] {IDLE, INIT, DRAW, SWAP, EMIT, LOAD0} state_t;

   state_t           state, state_d;
   logic [IDX_W-1:0] tbl [DEPTH];
   logic [IDX_W-1:0] nm1_q, k_q, i_q, j_q;
   logic [IDX_W-1:0] mask_c, j_c;
   logic             cnt_ok_c, start_ok_c, start_bad_c, accept_c, hs_c;
   logic             unused_rnd_c;

   assign unused_rnd_c = ^rnd_in[RND_W-1:IDX_W];

   // Smallest all-ones mask covering i, so rejection sampling stays unbiased
   always_comb begin
      mask_c = '0;
      for (int unsigned b = 0; b < IDX_W; b++) mask_c = mask_c | (i_q >> b);
   end

   assign j_c         = rnd_in[IDX_W-1:0] & mask_c;
   assign accept_c    = (j_c <= i_q);
   assign cnt_ok_c    = (count != '0) && (count <= CNT_W'(DEPTH));
   assign start_ok_c  = (state == IDLE) && start && cnt_ok_c;
   assign start_bad_c = (state == IDLE) && start && !cnt_ok_c;
   assign hs_c        = (state == EMIT) && out_ready;

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start_ok_c) state_d = INIT;
         INIT:    if (k_q == nm1_q) state_d = (nm1_q == '0) ? LOAD0 : DRAW;
         DRAW:    if (accept_c) state_d = SWAP;
         SWAP:    state_d = EMIT;
         EMIT: begin
            if (hs_c) begin
               if (i_q == '0)                state_d = IDLE;
               else if (i_q == IDX_W'(1))    state_d = LOAD0;
               else                          state_d = DRAW;
            end
         end
         LOAD0:   state_d = EMIT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rnd_en    <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         nm1_q     <= '0;
         k_q       <= '0;
         i_q       <= '0;
         j_q       <= '0;
      end else begin
         state     <= state_d;
         rnd_en    <= (state_d == DRAW);
         out_valid <= (state_d == EMIT);
         busy      <= (state_d != IDLE);
         done      <= hs_c && (i_q == '0);
         err       <= start_bad_c;
         case (state)
            IDLE: begin
               if (start_ok_c) begin
                  nm1_q <= IDX_W'(count - CNT_W'(1));
                  k_q   <= '0;
               end
            end
            INIT: begin
               k_q <= k_q + IDX_W'(1);
               if (k_q == nm1_q) i_q <= nm1_q;
            end
            DRAW: if (accept_c) j_q <= j_c;
            SWAP: begin
               out_idx  <= tbl[j_q];
               out_last <= 1'b0;
            end
            EMIT: begin
               if (hs_c) begin
                  out_last <= 1'b0;
                  if (i_q != '0) i_q <= i_q - IDX_W'(1);
               end
            end
            LOAD0: begin
               out_idx  <= tbl[0];
               out_last <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Index table is scratch storage; contents are rebuilt on every start
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         tbl[k_q] <= k_q;
      end else if (state == SWAP) begin
         tbl[i_q] <= tbl[j_q];
         tbl[j_q] <= tbl[i_q];
      end
   end

endmodule
